// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the arbiter state encoding, the default byte width and the grant-index width helper.
package uart_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

    // Width of an index into n requesters; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or above ptr_i,
// wrapping modulo N, reported as a one-hot grant, an index and an any-valid flag.
module rr_pick
    import uart_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        // Walk from the farthest candidate down so the nearest one to ptr_i wins last.
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N;
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte sources.
// Define UART_ARB_LOCK_EN to keep the grant on one requester until its req_last byte.
//
// state        | meaning
// ST_IDLE      | arbitrating; req_ready drives the winner
// ST_LAUNCH    | tx_start pulse, timeout counter loaded
// ST_WAIT_BUSY | waiting for tx_busy to rise, counting down to timeout
// ST_WAIT_DONE | waiting for tx_busy to fall
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int START_TO = 4,
    localparam int IW       = idx_w(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_busy,
    output logic [IW-1:0]           grant_id,
    output logic                    active,
    output logic                    err_timeout
);

    localparam int CW = $clog2(START_TO + 1);

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [DATA_W-1:0] data_q, data_d, win_data;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              start_q, active_q;

    logic [N_REQ-1:0]  pick_oh, win_oh;
    logic [IW-1:0]     pick_idx, win_idx;
    logic              pick_any, win_any;

`ifdef UART_ARB_LOCK_EN
    logic lock_q, lock_d;
`else
    logic lock_q;
    logic unused_last;
    assign lock_q      = 1'b0;
    assign unused_last = ^req_last;
`endif

    rr_pick #(.N(N_REQ)) u_pick (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_oh),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // A held lock pins the winner to the last grant and ignores everyone else.
    always_comb begin
        win_oh  = pick_oh;
        win_idx = pick_idx;
        win_any = pick_any;
        if (lock_q) begin
            win_oh          = '0;
            win_oh[grant_q] = req_valid[grant_q];
            win_idx         = grant_q;
            win_any         = req_valid[grant_q];
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == IW'(i)) win_data = req_data[i*DATA_W +: DATA_W];
        end
    end

    assign req_ready = (state_q == ST_IDLE) ? win_oh : '0;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
`ifdef UART_ARB_LOCK_EN
        lock_d   = lock_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    data_d  = win_data;
                    grant_d = win_idx;
                    if (!lock_q) begin
                        rr_ptr_d = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
                    end
`ifdef UART_ARB_LOCK_EN
                    lock_d = ~req_last[win_idx];
`endif
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = CW'(START_TO - 1);
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == '0) begin
                    err_d   = 1'b1;
`ifdef UART_ARB_LOCK_EN
                    lock_d  = 1'b0;
`endif
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            start_q  <= (state_d == ST_LAUNCH);
            active_q <= (state_d != ST_IDLE);
        end
    end

`ifdef UART_ARB_LOCK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lock_q <= 1'b0;
        else        lock_q <= lock_d;
    end
`endif

    assign tx_start    = start_q;
    assign tx_data     = data_q;
    assign grant_id    = grant_q;
    assign active      = active_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a queue/arithmetic reference model.
// Follows UART_ARB_LOCK_EN in the same way as the design.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        err_timeout;

    int tests = 0;
    int fails = 0;

    int m_ptr, m_grant;
    bit m_lock, m_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .START_TO(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .err_timeout (err_timeout)
    );

    function automatic int model_pick(input logic [3:0] v, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int lim, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (tx_start) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic busy_pulse(input int d, input int len);
        repeat (d) tick();
        tx_busy = 1'b1;
        repeat (len) tick();
        tx_busy = 1'b0;
    endtask

    task automatic apply_reset();
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        reset     = 1'b0;
        tick();
        tick();
        reset   = 1'b1;
        m_ptr   = 0;
        m_grant = 0;
        m_lock  = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        tests++;
        if ({tx_start, active, err_timeout} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: got start/active/err=%b want 000", {tx_start, active, err_timeout});
        end
        tests++;
        if (tx_data !== 8'h00 || grant_id !== 2'd0) begin
            fails++;
            $display("FAIL reset_data: got tx_data=%h grant=%0d want 00/0", tx_data, grant_id);
        end
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        tick();
    endtask

    task automatic test_single();
        bit bad;
        req_valid = 4'b0100;
        req_data  = 32'h0000_0000;
        req_data[23:16] = 8'h5A;
        #1;
        tests++;
        if (req_ready !== 4'b0100) begin
            fails++;
            $display("FAIL single_ready: got %b want 0100", req_ready);
        end
        tick();
        tests++;
        if (tx_start !== 1'b1 || tx_data !== 8'h5A || grant_id !== 2'd2) begin
            fails++;
            $display("FAIL single_launch: got start=%b data=%h grant=%0d want 1/5a/2", tx_start, tx_data, grant_id);
        end
        req_data[23:16] = 8'hA5;
        tx_busy = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (req_ready !== 4'b0000 || tx_start !== 1'b0 || active !== 1'b1) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL single_hold: ready/start/active wrong while busy, got ready=%b want 0000", req_ready);
        end
        tx_busy = 1'b0;
        tick();
        tests++;
        if (req_ready !== 4'b0100 || active !== 1'b0) begin
            fails++;
            $display("FAIL single_regrant_idle: got ready=%b active=%b want 0100/0", req_ready, active);
        end
        tick();
        tests++;
        if (tx_start !== 1'b1 || tx_data !== 8'hA5 || grant_id !== 2'd2) begin
            fails++;
            $display("FAIL single_second: got start=%b data=%h grant=%0d want 1/a5/2", tx_start, tx_data, grant_id);
        end
        req_valid = '0;
        busy_pulse(0, 2);
        tick();
        m_ptr = 3;
    endtask

    task automatic test_all_four();
        int exp_ord [5] = '{0, 1, 2, 3, 0};
        bit seen;
        apply_reset();
        req_valid = 4'b1111;
        req_data  = 32'h1312_1110;
        for (int i = 0; i < 5; i++) begin
            wait_start(6, seen);
            tests++;
            if (!seen || grant_id !== 2'(exp_ord[i]) || tx_data !== 8'(8'h10 + exp_ord[i])) begin
                fails++;
                $display("FAIL all_four_%0d: got seen=%b grant=%0d data=%h want 1/%0d/%h",
                         i, seen, grant_id, tx_data, exp_ord[i], 8'h10 + exp_ord[i]);
            end
            busy_pulse(1, 3);
        end
        req_valid = '0;
        tick();
        m_ptr = 1;
    endtask

    task automatic test_timeout();
        bit seen;
        bit act4, err4, act5, err5;
        req_valid = 4'b0010;
        req_data  = 32'h0000_7700;
        wait_start(6, seen);
        tests++;
        if (!seen || grant_id !== 2'd1 || tx_data !== 8'h77) begin
            fails++;
            $display("FAIL timeout_launch: got seen=%b grant=%0d data=%h want 1/1/77", seen, grant_id, tx_data);
        end
        req_valid = '0;
        act4 = 1'b0; err4 = 1'b0; act5 = 1'b0; err5 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 4) begin act4 = active; err4 = err_timeout; end
            if (k == 5) begin act5 = active; err5 = err_timeout; end
        end
        tests++;
        if (act4 !== 1'b1 || err4 !== 1'b0) begin
            fails++;
            $display("FAIL timeout_early: at cycle 4 got active=%b err=%b want 1/0", act4, err4);
        end
        tests++;
        if (act5 !== 1'b0 || err5 !== 1'b1) begin
            fails++;
            $display("FAIL timeout_expire: at cycle 5 got active=%b err=%b want 0/1", act5, err5);
        end
        m_err = 1'b1;
        m_ptr = 2;
        req_valid = 4'b1000;
        req_data  = 32'h3C00_0000;
        wait_start(6, seen);
        tests++;
        if (!seen || grant_id !== 2'd3 || tx_data !== 8'h3C) begin
            fails++;
            $display("FAIL timeout_next: got seen=%b grant=%0d data=%h want 1/3/3c", seen, grant_id, tx_data);
        end
        req_valid = '0;
        busy_pulse(0, 3);
        tick();
        tests++;
        if (err_timeout !== 1'b1) begin
            fails++;
            $display("FAIL timeout_sticky: got err=%b want 1", err_timeout);
        end
        m_ptr = 0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        req_valid = 4'b1110;
        req_data  = 32'h4433_2211;
        wait_start(6, seen);
        tests++;
        if (!seen || grant_id !== 2'd1 || tx_data !== 8'h22) begin
            fails++;
            $display("FAIL rstmid_launch: got seen=%b grant=%0d data=%h want 1/1/22", seen, grant_id, tx_data);
        end
        tx_busy = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        tests++;
        if ({tx_start, active, err_timeout} !== 3'b000 || tx_data !== 8'h00 || grant_id !== 2'd0) begin
            fails++;
            $display("FAIL rstmid_outputs: got start/active/err=%b data=%h grant=%0d want 000/00/0",
                     {tx_start, active, err_timeout}, tx_data, grant_id);
        end
        tx_busy = 1'b0;
        req_valid = 4'b1111;
        tick();
        tick();
        reset = 1'b1;
        m_ptr = 0; m_grant = 0; m_lock = 1'b0; m_err = 1'b0;
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL rstmid_ready: got %b want 0001", req_ready);
        end
        wait_start(6, seen);
        tests++;
        if (!seen || grant_id !== 2'd0 || tx_data !== 8'h11) begin
            fails++;
            $display("FAIL rstmid_grant: got seen=%b grant=%0d data=%h want 1/0/11", seen, grant_id, tx_data);
        end
        req_valid = '0;
        busy_pulse(0, 2);
        tick();
        m_ptr = 1;
    endtask

    task automatic test_random();
        bit seen;
        logic [3:0] v;
        int w;
        for (int it = 0; it < 40; it++) begin
            v = 4'($urandom_range(1, 15));
            if (m_lock) v[m_grant] = 1'b1;
            req_valid = v;
            req_data  = $urandom();
            req_last  = 4'($urandom());
            w = m_lock ? m_grant : model_pick(v, m_ptr);
            wait_start(8, seen);
            tests++;
            if (!seen || grant_id !== 2'(w) || tx_data !== req_data[w*8 +: 8]) begin
                fails++;
                $display("FAIL random_%0d: got seen=%b grant=%0d data=%h want 1/%0d/%h",
                         it, seen, grant_id, tx_data, w, req_data[w*8 +: 8]);
            end
            if (!m_lock) m_ptr = (w + 1) % 4;
            m_grant = w;
`ifdef UART_ARB_LOCK_EN
            m_lock = ~req_last[w];
`endif
            if ($urandom_range(0, 7) == 0) begin
                repeat (5) tick();
                m_err  = 1'b1;
                m_lock = 1'b0;
            end else begin
                busy_pulse($urandom_range(0, 2), $urandom_range(2, 6));
                tick();
            end
            tests++;
            if (err_timeout !== m_err || active !== 1'b0) begin
                fails++;
                $display("FAIL random_err_%0d: got err=%b active=%b want %b/0", it, err_timeout, active, m_err);
            end
        end
        req_valid = '0;
        req_last  = '0;
        tick();
    endtask

    task automatic test_lock();
        bit seen;
        logic [7:0] b1 [3] = '{8'hB1, 8'hB2, 8'hB3};
        logic [7:0] a0 [3] = '{8'hA0, 8'hA1, 8'hA2};
`ifdef UART_ARB_LOCK_EN
        int exp_g [4] = '{1, 1, 1, 0};
`else
        int exp_g [4] = '{1, 0, 1, 0};
`endif
        int i0, i1;
        logic [7:0] exp_d;
        apply_reset();
        i0 = 0;
        i1 = 0;
        for (int s = 0; s < 4; s++) begin
            req_valid = (s == 0) ? 4'b0010 : (i1 < 3 ? 4'b0011 : 4'b0001);
            req_data  = {16'h0000, b1[i1 < 3 ? i1 : 2], a0[i0]};
            req_last  = {2'b00, (i1 == 2), 1'b1};
            exp_d = (exp_g[s] == 1) ? b1[i1] : a0[i0];
            wait_start(6, seen);
            tests++;
            if (!seen || grant_id !== 2'(exp_g[s]) || tx_data !== exp_d) begin
                fails++;
                $display("FAIL lock_seq_%0d: got seen=%b grant=%0d data=%h want 1/%0d/%h",
                         s, seen, grant_id, tx_data, exp_g[s], exp_d);
            end
            if (exp_g[s] == 1) i1++;
            else               i0++;
            busy_pulse(0, 2);
            tick();
        end
        req_valid = '0;
        req_last  = '0;
        tick();
    endtask

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        reset     = 1'b0;
        test_reset();
        test_single();
        test_all_four();
        test_timeout();
        test_reset_mid();
        test_random();
        test_lock();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART `Transmitter` between up to `N_REQ` byte sources. It sits between the requesters (debounced-button/switch path, status reporters, and so on) and the `Transmitter` instance. It accepts one byte at a time over a valid/ready handshake and issues a one-cycle start pulse with the byte. It then waits for the transmitter's busy signal to rise and fall before granting again.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: byte width.
- `START_TO`, 4: cycles allowed for `tx_busy` to rise after `tx_start`.

Ports:
- `clk`  in  1  system clock; the single clock for the block.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `req_valid`  in  N_REQ  per-requester byte available.
- `req_data`  in  N_REQ*DATA_W  flattened; requester i at bits [i*DATA_W +: DATA_W].
- `req_last`  in  N_REQ  last byte of a message; used only with `UART_ARB_LOCK_EN`.
- `req_ready`  out  N_REQ  one-hot or zero; a byte transfers when valid and ready are both high at a clock edge.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_data`  out  DATA_W  byte to send; held stable from `tx_start` until return to IDLE.
- `tx_busy`  in  1  transmitter busy while shifting a frame.
- `grant_id`  out  $clog2(N_REQ)  index of the current or last grant.
- `active`  out  1  high in any state other than IDLE.
- `err_timeout`  out  1  sticky; set when a start timeout occurs.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - `req_ready` is driven combinationally, one-hot, to the winner.
  - The winner is the first `req_valid` at or above `rr_ptr`, searching upward and wrapping modulo N_REQ.
  - On transfer: latch `req_data` slice into `tx_data`, latch the winner into `grant_id`, set `rr_ptr` to winner+1 (mod N_REQ), go to LAUNCH.
  - With no valid request, stay in IDLE and leave `rr_ptr` unchanged.
- LAUNCH: `tx_start`=1 for exactly this cycle, then go to WAIT_BUSY. Clear the timeout counter.
- WAIT_BUSY:
  - If `tx_busy`=1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches START_TO, set `err_timeout` and go to IDLE.
  - The byte is dropped on timeout; no retry.
- WAIT_DONE: when `tx_busy`=0, go to IDLE.
- `req_ready` is 0 in every state except IDLE.
- `tx_busy` high while in IDLE has no effect on arbitration. The arbiter relies on WAIT_DONE for pacing.
- Reset values:
  - State IDLE; `rr_ptr`=0; `grant_id`=0.
  - `tx_data`=0; `tx_start`=0; `active`=0; `err_timeout`=0.
  - Any in-flight byte is abandoned. The transmitter's own reset covers the line.
- `err_timeout` clears only on reset.

## Timing
- Accept edge → `tx_start` high in the next cycle, so latency is 1 cycle.
- Minimum per-byte occupancy is 1 (IDLE) + 1 (LAUNCH) + 1 + busy duration + 1 cycles.
- Next grant: earliest on the first IDLE cycle after `tx_busy` is seen low in WAIT_DONE.
- All outputs are registered except `req_ready`, which is combinational from `req_valid`, state, and `rr_ptr`.
- Simultaneous requests are resolved by `rr_ptr` only. Requests that are not granted must hold their `req_valid`, and their data stays pending.
- A requester that drops `req_valid` before being granted is simply skipped.

## Configuration
- `UART_ARB_LOCK_EN` defined:
  - A transfer with `req_last`=0 sets `lock`.
  - While locked, the IDLE winner is forced to `grant_id`, and `rr_ptr` does not advance.
  - A transfer with `req_last`=1 clears `lock`.
  - A start timeout clears `lock`.
  - Reset value of `lock` is 0.
- Not defined: `req_last` is ignored, and every byte re-arbitrates.

## Structure
- Shared package `uart_pkg`:
  - State enum `arb_state_t`.
  - Default `DATA_W`.
  - Helper constant for the `grant_id` width.
- One sub-module, `rr_pick`: combinational round-robin priority picker. Inputs are the request vector and the pointer; outputs are one-hot grant, index, and any-valid.

## Test plan
- Single requester: `req_valid[2]`=1, data 0x5A. Expect `req_ready[2]` in the first cycle, `tx_start` one cycle later with `tx_data`=0x5A and `grant_id`=2. Model `tx_busy` high for 10 cycles; expect the next grant no earlier than the first IDLE cycle after `tx_busy` is seen low.
- All four valid continuously with data 0x10..0x13. Expect grant order 0,1,2,3,0 and the same bytes on `tx_data`.
- Timeout: never raise `tx_busy`. Expect return to IDLE 4 cycles after WAIT_BUSY entry, `err_timeout`=1 sticky, and the next request still served.
- Reset mid-frame: drive `reset`=0 during WAIT_DONE. Expect all outputs at reset values immediately, and `rr_ptr`=0 after release, so requester 0 wins.
- `UART_ARB_LOCK_EN`: requester 1 sends 3 bytes with `req_last`=0,0,1 while requester 0 is also valid. Expect three consecutive grants to 1, then a grant to 2 or 0 per `rr_ptr`=2.
- Lock disabled, same stimulus: expect grants alternating 1,0,1,…
